// File: rtl/dmem_wait_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_wait_ctrl
// Wait-state data-memory controller between a single-cycle datapath and a
// word-addressed data RAM. Each load/store holds Ready low for LATENCY+1
// cycles and then raises it for one DONE cycle. Load data appears on memout
// in that DONE cycle and is held until the next load.
//
// Optional feature (compile-time macro DMEM_ALIGN_CHK_EN):
//   Adds the misalign output. An access whose byte address is not word
//   aligned keeps the normal timing but neither writes RAM nor updates
//   memout, and misalign pulses high in its DONE cycle.
// ---------------------------------------------------------------------------
module dmem_wait_ctrl #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active low
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] memout,
`ifdef DMEM_ALIGN_CHK_EN
  output logic        Ready,
  output logic        misalign
`else
  output logic        Ready
`endif
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_data;
  logic            r_op_wr;
  logic            r_bad_align;
  logic [31:0]     r_memout;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_start;
  logic            w_last;
  logic            w_do_write;
  logic            w_do_read;
  logic            w_addr_bad;

  assign w_req   = MemRead | MemWrite;
  assign w_start = (r_state == ST_IDLE) && w_req;
  assign w_last  = (r_state == ST_BUSY) && (r_cnt == CW'(1));

`ifdef DMEM_ALIGN_CHK_EN
  assign w_addr_bad = (Address[1:0] != 2'b00);
  logic [31-AW-2:0] w_unused_addr;
  assign w_unused_addr = Address[31:AW+2];
`else
  // Byte offset is meaningless without the alignment check.
  assign w_addr_bad = 1'b0;
  logic [31-AW:0] w_unused_addr;
  assign w_unused_addr = {Address[31:AW+2], Address[1:0]};
`endif

  // Commit only on the final BUSY edge; a reset asserted in BUSY aborts it.
  assign w_do_write = w_last && r_op_wr  && !r_bad_align && reset;
  assign w_do_read  = w_last && !r_op_wr && !r_bad_align;

  assign Ready  = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
  assign memout = r_memout;

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = (r_state == ST_DONE) && r_bad_align;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> BUSY on a request, BUSY -> DONE on the last
  // wait cycle, DONE -> IDLE unconditionally.
  always_comb begin
    // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:             w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and load-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_op_wr     <= 1'b0;
      r_bad_align <= 1'b0;
      r_memout    <= '0;
    end else begin
      if (w_start) begin
        r_cnt       <= CW'(LATENCY);
        r_idx       <= Address[AW+1:2];
        r_data      <= WriteData;
        r_op_wr     <= MemWrite;     // simultaneous read+write resolves to write
        r_bad_align <= w_addr_bad;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_do_read) r_memout <= r_mem[r_idx];
    end
  end

  // Data RAM write port.
  // NOTE: the RAM has no reset so it maps onto memory primitives; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_idx] <= r_data;
  end

endmodule
